// File: rtl/pipe_collision_scorer.sv
// pipe_collision_scorer: per-game-step crash/score decision for the pipe game.
// A Tick starts a 3-stage evaluation: capture inputs, register the geometric
// compares, then advance the game FSM, Score, HiScore and the Status/Crash/Restart
// outputs. The player button is synchronised and latched as a pending press.
module pipe_collision_scorer #(
  parameter int BIRD_X     = 200,
  parameter int BIRD_W     = 34,
  parameter int BIRD_H     = 24,
  parameter int PIPE_W     = 90,
  parameter int CAP_H      = 33,
  parameter int GAP        = 150,
  parameter int FLOOR_Y    = 428,
  parameter int HOLD_TICKS = 64
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Tick,
  input  logic        Button,
  input  logic [15:0] PipesPosition,
  input  logic [15:0] PipesLong,
  input  logic [15:0] BirdY,
  output logic        Status,
  output logic        Crash,
  output logic        Restart,
  output logic [15:0] Score,
  output logic [15:0] HiScore
);

  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HIT  = 2'd2,
    S_OVER = 2'd3
  } state_t;

  // BCD increment with ripple carry; 9999 saturates.
  function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v == 16'h9999) begin
      r = v;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
            carry       = 1'b1;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Button synchroniser / press latch
  logic btn_s1_q, btn_s2_q, btn_s3_q, press_pend_q, press_pend_d;
  logic press_edge_s, consume_s;
  // Pipeline stage 1 (captured inputs) and stage 2 (registered compares)
  logic        v1_q, v1_d, v2_q, v2_d;
  logic [15:0] p_q, p_d, long_q, long_d, birdy_q, birdy_d;
  logic        hit_q, hit_d, pass_q, pass_d, wrap_q, wrap_d;
  logic [16:0] p_ext_s, l_ext_s, y_ext_s;
  logic        x_ovl_s, y_hit_s, floor_s;
  // Game state
  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                scored_q, scored_d;
  logic [15:0]         score_q, score_d, hiscore_q, hiscore_d;
  logic                status_q, status_d, crash_q, crash_d, restart_q, restart_d;

  // Press edge: synchronised level falling from released (1) to pressed (0).
  always_comb begin
    press_edge_s = btn_s3_q & ~btn_s2_q;
    press_pend_d = (press_pend_q & ~consume_s) | press_edge_s;
  end

  // Stage 1 capture on Tick and stage 2 geometric compares (17-bit, no wrap).
  always_comb begin
    v1_d    = Tick;
    v2_d    = v1_q;
    p_d     = p_q;
    long_d  = long_q;
    birdy_d = birdy_q;
    hit_d   = hit_q;
    pass_d  = pass_q;
    wrap_d  = wrap_q;
    p_ext_s = {1'b0, p_q};
    l_ext_s = {1'b0, long_q};
    y_ext_s = {1'b0, birdy_q};
    x_ovl_s = (17'(BIRD_X + BIRD_W) >= p_ext_s) && (17'(BIRD_X) <= p_ext_s + 17'(PIPE_W));
    y_hit_s = (y_ext_s <= l_ext_s + 17'(CAP_H)) || (y_ext_s + 17'(BIRD_H) >= l_ext_s + 17'(GAP));
    floor_s = (y_ext_s + 17'(BIRD_H) >= 17'(FLOOR_Y));
    if (Tick) begin
      p_d     = PipesPosition;
      long_d  = PipesLong;
      birdy_d = BirdY;
    end else begin
      p_d     = p_q;
    end
    if (v1_q) begin
      hit_d  = (x_ovl_s && y_hit_s) || floor_s;
      pass_d = (p_ext_s + 17'(PIPE_W)) < 17'(BIRD_X);
      wrap_d = p_ext_s > 17'(BIRD_X + BIRD_W);
    end else begin
      hit_d  = hit_q;
    end
  end

  // Game FSM: advances only on the evaluation cycle of a step.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    scored_d   = scored_q;
    score_d    = score_q;
    hiscore_d  = hiscore_q;
    crash_d    = 1'b0;
    restart_d  = 1'b0;
    consume_s  = 1'b0;
    if (v2_q) begin
      case (state_q)
        S_IDLE: begin
          if (press_pend_q) begin
            state_d   = S_RUN;
            score_d   = 16'h0000;
            scored_d  = 1'b0;
            consume_s = 1'b1;
          end else begin
            state_d   = S_IDLE;
          end
        end
        S_RUN: begin
          if (hit_q) begin
            state_d    = S_HIT;
            crash_d    = 1'b1;
            hold_cnt_d = '0;
          end else if (pass_q && !scored_q) begin
            score_d  = bcd_inc_sat(score_q);
            scored_d = 1'b1;
          end else if (wrap_q) begin
            scored_d = 1'b0;
          end else begin
            scored_d = scored_q;
          end
        end
        S_HIT: begin
          if (hold_cnt_q == HOLD_W'(HOLD_TICKS - 1)) begin
            state_d   = S_OVER;
            consume_s = 1'b1;
            if (score_q > hiscore_q) begin
              hiscore_d = score_q;
            end else begin
              hiscore_d = hiscore_q;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        S_OVER: begin
          if (press_pend_q) begin
            state_d   = S_IDLE;
            restart_d = 1'b1;
            consume_s = 1'b1;
          end else begin
            state_d   = S_OVER;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    status_d = (state_d == S_RUN);
  end

  // State and pipeline registers; async reset to the idle/released state.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      btn_s1_q     <= 1'b1;
      btn_s2_q     <= 1'b1;
      btn_s3_q     <= 1'b1;
      press_pend_q <= 1'b0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      p_q          <= 16'h0000;
      long_q       <= 16'h0000;
      birdy_q      <= 16'h0000;
      hit_q        <= 1'b0;
      pass_q       <= 1'b0;
      wrap_q       <= 1'b0;
      state_q      <= S_IDLE;
      hold_cnt_q   <= '0;
      scored_q     <= 1'b0;
      score_q      <= 16'h0000;
      hiscore_q    <= 16'h0000;
      status_q     <= 1'b0;
      crash_q      <= 1'b0;
      restart_q    <= 1'b0;
    end else begin
      btn_s1_q     <= Button;
      btn_s2_q     <= btn_s1_q;
      btn_s3_q     <= btn_s2_q;
      press_pend_q <= press_pend_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      p_q          <= p_d;
      long_q       <= long_d;
      birdy_q      <= birdy_d;
      hit_q        <= hit_d;
      pass_q       <= pass_d;
      wrap_q       <= wrap_d;
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      scored_q     <= scored_d;
      score_q      <= score_d;
      hiscore_q    <= hiscore_d;
      status_q     <= status_d;
      crash_q      <= crash_d;
      restart_q    <= restart_d;
    end
  end

  assign Status  = status_q;
  assign Crash   = crash_q;
  assign Restart = restart_q;
  assign Score   = score_q;
  assign HiScore = hiscore_q;

endmodule

// File: tb/tb_pipe_collision_scorer.sv
// Bench for pipe_collision_scorer: scenario tasks plus a randomized run, all
// checked against a game-rule model that tracks mode, decimal score and hiscore.
module tb_pipe_collision_scorer;

  localparam int BIRD_X = 200, BIRD_W = 34, BIRD_H = 24, PIPE_W = 90;
  localparam int CAP_H = 33, GAP = 150, FLOOR_Y = 428, HOLD_TICKS = 64;
  localparam int M_IDLE = 0, M_RUN = 1, M_HIT = 2, M_OVER = 3;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Tick = 1'b0;
  logic        Button = 1'b1;
  logic [15:0] PipesPosition = 16'd0, PipesLong = 16'd0, BirdY = 16'd0;
  logic        Status, Crash, Restart;
  logic [15:0] Score, HiScore;

  int total = 0;
  int bad = 0;

  // model state
  int m_mode, m_score, m_hi, m_scored, m_pend, m_hit_steps;
  logic e_status, e_crash, e_restart;
  // observed values from the latest step
  logic o_status, o_crash, o_restart, o_crash_late, o_restart_late;
  logic [15:0] o_score, o_hi;

  pipe_collision_scorer dut (
    .clk(clk), .Reset(Reset), .Tick(Tick), .Button(Button),
    .PipesPosition(PipesPosition), .PipesLong(PipesLong), .BirdY(BirdY),
    .Status(Status), .Crash(Crash), .Restart(Restart),
    .Score(Score), .HiScore(HiScore)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_score = 0; m_hi = 0; m_scored = 0; m_pend = 0; m_hit_steps = 0;
  endtask

  // Game rules applied to one step's inputs.
  task automatic model_step(input int p, input int l, input int y);
    bit hit, pass;
    hit  = ((BIRD_X + BIRD_W >= p) && (BIRD_X <= p + PIPE_W) &&
            ((y <= l + CAP_H) || (y + BIRD_H >= l + GAP))) || (y + BIRD_H >= FLOOR_Y);
    pass = (p + PIPE_W < BIRD_X);
    e_crash = 1'b0; e_restart = 1'b0;
    if (m_mode == M_IDLE) begin
      if (m_pend != 0) begin m_mode = M_RUN; m_score = 0; m_scored = 0; m_pend = 0; end
    end else if (m_mode == M_RUN) begin
      if (hit) begin
        m_mode = M_HIT; e_crash = 1'b1; m_hit_steps = 0;
      end else begin
        if (pass && m_scored == 0) begin
          if (m_score < 9999) m_score = m_score + 1;
          m_scored = 1;
        end
        if (p > BIRD_X + BIRD_W) m_scored = 0;
      end
    end else if (m_mode == M_HIT) begin
      m_hit_steps = m_hit_steps + 1;
      if (m_hit_steps == HOLD_TICKS) begin
        m_mode = M_OVER; m_pend = 0;
        if (m_score > m_hi) m_hi = m_score;
      end
    end else begin
      if (m_pend != 0) begin m_mode = M_IDLE; e_restart = 1'b1; m_pend = 0; end
    end
    e_status = (m_mode == M_RUN);
  endtask

  // One game step: Tick with the given inputs, garbage between Ticks,
  // outputs captured at T+3 and one cycle later.
  task automatic step(input int p, input int l, input int y);
    @(negedge clk);
    PipesPosition = 16'(p); PipesLong = 16'(l); BirdY = 16'(y); Tick = 1'b1;
    @(negedge clk);
    Tick = 1'b0;
    PipesPosition = 16'($urandom); PipesLong = 16'($urandom); BirdY = 16'($urandom);
    model_step(p, l, y);
    @(posedge clk); @(posedge clk); #1;
    o_status = Status; o_crash = Crash; o_restart = Restart; o_score = Score; o_hi = HiScore;
    @(posedge clk); #1;
    o_crash_late = Crash; o_restart_late = Restart;
  endtask

  task automatic press();
    @(negedge clk); Button = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); Button = 1'b1;
    repeat (4) @(posedge clk);
    m_pend = 1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; model_reset();
    #1;
    total++; if (Status !== 1'b0) begin bad++; $display("FAIL reset_status got=%b want=0", Status); end
    total++; if (Crash !== 1'b0) begin bad++; $display("FAIL reset_crash got=%b want=0", Crash); end
    total++; if (Restart !== 1'b0) begin bad++; $display("FAIL reset_restart got=%b want=0", Restart); end
    total++; if (Score !== 16'h0000) begin bad++; $display("FAIL reset_score got=%h want=0000", Score); end
    total++; if (HiScore !== 16'h0000) begin bad++; $display("FAIL reset_hiscore got=%h want=0000", HiScore); end
    repeat (2) @(posedge clk);
    @(negedge clk); Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(int'($urandom_range(0, 700)), int'($urandom_range(0, 300)), int'($urandom_range(0, 450)));
      total++;
      if (o_status !== e_status || o_crash !== 1'b0 || o_score !== 16'h0000) begin
        bad++; $display("FAIL idle_ticks i=%0d got st=%b cr=%b sc=%h want st=%b cr=0 sc=0000",
                        i, o_status, o_crash, o_score, e_status);
      end
    end
  endtask

  task automatic test_start();
    press();
    step(300, 100, 200);
    total++; if (o_status !== 1'b1 || o_status !== e_status) begin
      bad++; $display("FAIL start_status got=%b want=1", o_status); end
    for (int i = 0; i < 5; i++) begin
      step(300, 100, 200);
      total++; if (o_crash !== e_crash || o_status !== e_status) begin
        bad++; $display("FAIL run_nocrash got cr=%b st=%b want cr=%b st=%b", o_crash, o_status, e_crash, e_status); end
    end
  endtask

  task automatic test_score_sweep();
    int change_p;
    logic [15:0] prev;
    change_p = -1; prev = 16'h0000;
    for (int p = 300; p >= 0; p--) begin
      step(p, 100, 200);
      total++; if (o_score !== to_bcd(m_score) || o_crash !== 1'b0) begin
        bad++; $display("FAIL sweep p=%0d got sc=%h cr=%b want sc=%h cr=0", p, o_score, o_crash, to_bcd(m_score)); end
      if (o_score !== prev && change_p < 0) change_p = p;
      prev = o_score;
    end
    total++; if (change_p != 109) begin bad++; $display("FAIL sweep_point got=%0d want=109", change_p); end
    total++; if (o_score !== 16'h0001) begin bad++; $display("FAIL sweep_once got=%h want=0001", o_score); end
    step(640, 100, 200);
    total++; if (o_score !== 16'h0001) begin bad++; $display("FAIL after_wrap got=%h want=0001", o_score); end
    for (int p = 300; p >= 100; p -= 3) step(p, 100, 200);
    total++; if (o_score !== 16'h0002 || o_score !== to_bcd(m_score)) begin
      bad++; $display("FAIL second_pass got=%h want=0002", o_score); end
  endtask

  task automatic run_out_hit(input string tag);
    press();  // pressed while in HIT: must be discarded
    for (int i = 0; i < HOLD_TICKS; i++) begin
      step(500, 100, 200);
      total++; if (o_status !== 1'b0 || o_restart !== 1'b0) begin
        bad++; $display("FAIL %s_hold i=%0d got st=%b rs=%b want 0 0", tag, i, o_status, o_restart); end
    end
    total++; if (o_hi !== to_bcd(m_hi) || o_score !== to_bcd(m_score)) begin
      bad++; $display("FAIL %s_hiscore got hi=%h sc=%h want hi=%h sc=%h", tag, o_hi, o_score, to_bcd(m_hi), to_bcd(m_score)); end
    step(500, 100, 200);
    total++; if (o_restart !== 1'b0 || o_status !== 1'b0) begin
      bad++; $display("FAIL %s_over_hold got rs=%b st=%b want 0 0", tag, o_restart, o_status); end
    press(); step(500, 100, 200);
    total++; if (o_restart !== 1'b1 || o_restart_late !== 1'b0 || o_status !== 1'b0) begin
      bad++; $display("FAIL %s_restart got rs=%b late=%b st=%b want 1 0 0", tag, o_restart, o_restart_late, o_status); end
    press(); step(640, 100, 200);
    total++; if (o_status !== 1'b1 || o_score !== 16'h0000) begin
      bad++; $display("FAIL %s_newgame got st=%b sc=%h want 1 0000", tag, o_status, o_score); end
  endtask

  task automatic test_crash_hold();
    step(180, 100, 120);
    total++; if (o_crash !== 1'b1 || o_crash_late !== 1'b0 || o_status !== 1'b0) begin
      bad++; $display("FAIL pipe_crash got cr=%b late=%b st=%b want 1 0 0", o_crash, o_crash_late, o_status); end
    run_out_hit("pipe");
    total++; if (o_hi !== 16'h0002) begin bad++; $display("FAIL hiscore_kept got=%h want=0002", o_hi); end
  endtask

  task automatic test_floor();
    step(900, 100, 410);
    total++; if (o_crash !== 1'b1 || o_status !== 1'b0) begin
      bad++; $display("FAIL floor_crash got cr=%b st=%b want 1 0", o_crash, o_status); end
    run_out_hit("floor");
  endtask

  task automatic test_random();
    int p, l, y;
    for (int i = 0; i < 250; i++) begin
      if ((m_mode == M_IDLE || m_mode == M_OVER) && $urandom_range(0, 1) == 1) press();
      p = int'($urandom_range(0, 700));
      l = int'($urandom_range(0, 250));
      if ($urandom_range(0, 9) < 7) y = l + int'($urandom_range(34, 125));
      else y = int'($urandom_range(0, 450));
      step(p, l, y);
      total++;
      if (o_status !== e_status || o_crash !== e_crash || o_restart !== e_restart ||
          o_score !== to_bcd(m_score) || o_hi !== to_bcd(m_hi) ||
          o_crash_late !== 1'b0 || o_restart_late !== 1'b0) begin
        bad++;
        $display("FAIL random i=%0d p=%0d l=%0d y=%0d got st=%b cr=%b rs=%b sc=%h hi=%h want st=%b cr=%b rs=%b sc=%h hi=%h",
                 i, p, l, y, o_status, o_crash, o_restart, o_score, o_hi,
                 e_status, e_crash, e_restart, to_bcd(m_score), to_bcd(m_hi));
      end
    end
  endtask

  task automatic test_saturation();
    @(negedge clk); Reset = 1'b0; model_reset();
    @(negedge clk); Reset = 1'b1;
    press(); step(640, 100, 200);
    @(negedge clk); force dut.score_q = 16'h0999;
    @(posedge clk);
    @(negedge clk); release dut.score_q;
    m_score = 999;
    step(50, 100, 200);
    total++; if (o_score !== 16'h1000) begin bad++; $display("FAIL bcd_carry got=%h want=1000", o_score); end
    step(640, 100, 200);
    @(negedge clk); force dut.score_q = 16'h9998;
    @(posedge clk);
    @(negedge clk); release dut.score_q;
    m_score = 9998;
    step(50, 100, 200);
    total++; if (o_score !== 16'h9999) begin bad++; $display("FAIL to_9999 got=%h want=9999", o_score); end
    step(640, 100, 200);
    step(50, 100, 200);
    total++; if (o_score !== 16'h9999 || o_score !== to_bcd(m_score)) begin
      bad++; $display("FAIL saturate got=%h want=9999", o_score); end
    step(180, 100, 120);
    total++; if (o_crash !== 1'b1) begin bad++; $display("FAIL sat_crash got=%b want=1", o_crash); end
    step(500, 100, 200); step(500, 100, 200);
    @(negedge clk); Reset = 1'b0; model_reset();
    #1;
    total++; if (Status !== 1'b0 || Crash !== 1'b0 || Restart !== 1'b0 || Score !== 16'h0000 || HiScore !== 16'h0000) begin
      bad++; $display("FAIL midhit_reset got st=%b cr=%b rs=%b sc=%h hi=%h want all 0", Status, Crash, Restart, Score, HiScore); end
    repeat (2) @(posedge clk); #1;
    total++; if (Crash !== 1'b0 || Restart !== 1'b0) begin
      bad++; $display("FAIL reset_nopulse got cr=%b rs=%b want 0 0", Crash, Restart); end
    @(negedge clk); Reset = 1'b1;
    step(300, 100, 200);
    total++; if (o_status !== 1'b0 || o_crash !== 1'b0 || o_restart !== 1'b0 || o_status !== e_status) begin
      bad++; $display("FAIL post_reset_idle got st=%b cr=%b rs=%b want 0 0 0", o_status, o_crash, o_restart); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_score_sweep();
    test_crash_hold();
    test_floor();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
